load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits between the MEM pipeline stage and data_memory, which is word-addressed, has no byte enables and reads combinationally. Accepts one load/store request at a time over a valid/ready handshake. Performs byte/halfword extraction with sign/zero extension on loads, and read-modify-write for SB/SH stores. Flags misaligned or out-of-range accesses instead of touching memory.

Parameters:
DEPTH, 32, number of 32-bit words in data_memory; legal word index range is 0..DEPTH-1.
IDX_W, 32, width of the word index driven to data_memory.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  32  byte address.
req_wdata  in  32  store data; low bits are used for B/H.
resp_valid  out  1  response available.
resp_ready  in  1  consumer accepts the response.
resp_rdata  out  32  formatted load data; 0 for stores and errors.
resp_err  out  1  misaligned access, out-of-range access, or illegal funct3.
mem_addr  out  IDX_W  word index, equal to req_addr[31:2] as latched.
mem_wdata  out  32  word to write.
mem_wr_en  out  1  write strobe to data_memory.
mem_rdata  in  32  combinational read data from data_memory.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE, all latched fields cleared.
  - Outputs during reset: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_wr_en = 0, mem_addr = 0, mem_wdata = 0.
  - Reset during any state aborts the operation; mem_wr_en drops immediately because it is decoded from state.
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - Accept on the edge where req_valid and req_ready are both high; latch we, funct3, addr and wdata.
  - If the access is illegal, go to RESP with err = 1 and no memory access. Illegal means any of:
    - H/HU with addr[0] = 1;
    - W with addr[1:0] != 0;
    - word index >= DEPTH;
    - funct3 not in the listed set; stores additionally reject 100 and 101.
  - Otherwise go to ACCESS.
- ACCESS: mem_addr is driven.
  - Load: on the next edge, capture the formatted mem_rdata into resp_rdata, then go to RESP.
  - SW: mem_wr_en = 1 and mem_wdata = wdata; the write lands on the next edge, then go to RESP.
  - SB/SH: mem_wr_en = 0; capture mem_rdata into the merge register, then go to MERGE.
- MERGE (SB/SH only): mem_wr_en = 1; mem_wdata = the merge word with the addressed byte or halfword replaced by wdata[7:0] or wdata[15:0]. Next state is RESP.
- Lane selection:
  - Byte lane = addr[1:0]; lane 0 is bits 7:0 (little-endian).
  - Halfword lane = addr[1]; lane 0 is bits 15:0.
- Load formatting:
  - B/H sign-extend bit 7 or bit 15 to 32 bits.
  - BU/HU zero-extend.
  - W passes mem_rdata through unchanged.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready is high.
  - On the handshake edge, return to IDLE and clear resp_rdata and resp_err.
  - No new request is accepted in RESP; req_ready = 0.
- Latency, counted in edges from the accept edge to the first cycle of resp_valid:
  - error: 1;
  - load and SW: 2;
  - SB/SH: 3.
  - A response accepted immediately frees the unit for a new accept on the following edge.
- mem_wr_en is high only in ACCESS for SW and in MERGE; a load never writes.
- mem_addr holds its latched value outside IDLE and is 0 in IDLE.

Decomposition:
- Shared package (riscv_pkg): funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the lsu state encoding constants.
- One natural sub-module: lsu_align, purely combinational. It provides load extraction/extension (rdata, funct3, addr[1:0]) and store merge (old word, wdata, funct3, addr[1:0]). The FSM stays in load_store_unit.

Test Plan:
- SW addr 0x0000_0008, wdata 0xDEADBEEF, then LW 0x8 -> exactly one mem_wr_en pulse with mem_addr = 2; the load returns resp_rdata = 0xDEADBEEF, err = 0, 2 edges after accept.
- Word 2 = 0xDEADBEEF, then LB 0xB -> 0xFFFFFFDE; LBU 0xB -> 0x000000DE; LH 0x8 -> 0xFFFFBEEF; LHU 0xA -> 0x0000DEAD.
- Word 2 = 0xDEADBEEF, then SB 0x9 with wdata 0x12 -> ACCESS read with no write, then MERGE writes 0xDEAD12EF; following LW 0x8 = 0xDEAD12EF.
- LW 0x6, SH 0x3, and LW 0x80 (index 32 >= DEPTH) -> each gives resp_err = 1 after 1 edge, resp_rdata = 0, and no mem_wr_en pulse.
- Hold resp_ready = 0 for 4 cycles after a load -> resp_valid and resp_rdata stay stable and req_ready stays 0; release resp_ready -> IDLE on the next edge.
- Assert reset while in MERGE of an SH -> mem_wr_en falls immediately; the memory word is unchanged; req_ready = 1 and resp_valid = 0 after reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes and LSU state encoding.
package riscv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension and SB/SH read-modify-write merge.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'd0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'd0, w_half};
      F3_W:    o_load = i_rdata;
      default: o_load = '0;
    endcase
  end

  always_comb begin
    o_merge = i_old;
    case (i_funct3)
      F3_B: o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
        else           o_merge[15:0]  = i_wdata[15:0];
      end
      default: o_merge = i_old;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-addressed memory without byte enables.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_wr_en,
  input  logic [31:0]      mem_rdata
);
  lsu_state_e  r_state, w_next;
  logic        r_we, r_err;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata, r_merge, r_rdata;
  logic        w_illegal, w_accept, w_is_sw;
  logic [31:0] w_load, w_merge;

  always_comb begin
    case (req_funct3)
      F3_B:         w_illegal = 1'b0;
      F3_BU, F3_HU: w_illegal = req_we | (req_funct3 == F3_HU && req_addr[0]);
      F3_H:         w_illegal = req_addr[0];
      F3_W:         w_illegal = |req_addr[1:0];
      default:      w_illegal = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH)) w_illegal = 1'b1;
  end

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_is_sw  = r_we && (r_f3 == F3_W);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = w_illegal ? ST_RESP : ST_ACCESS;
      ST_ACCESS: w_next = (r_we && !w_is_sw) ? ST_MERGE : ST_RESP;
      ST_MERGE:  w_next = ST_RESP;
      ST_RESP:   if (resp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_we    <= req_we;
          r_f3    <= req_funct3;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_err   <= w_illegal;
        end
        ST_ACCESS: begin
          if (!r_we)         r_rdata <= w_load;
          else if (!w_is_sw) r_merge <= mem_rdata;
        end
        ST_RESP: if (resp_ready) begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  lsu_align u_align (
    .i_rdata  (mem_rdata),
    .i_funct3 (r_f3),
    .i_lane   (r_addr[1:0]),
    .i_old    (r_merge),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  // Write strobe is a pure state decode so reset kills it without waiting for an edge.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    if (r_state == ST_ACCESS && w_is_sw) begin
      mem_wr_en = 1'b1;
      mem_wdata = r_wdata;
    end else if (r_state == ST_MERGE) begin
      mem_wr_en = 1'b1;
      mem_wdata = w_merge;
    end
  end

  assign mem_addr   = (r_state == ST_IDLE) ? '0 : IDX_W'(r_addr[31:2]);
  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized checks of load_store_unit against a byte-arithmetic memory model.
module tb_load_store_unit;
  localparam int DEPTH = 32;
  localparam int IDX_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]       req_funct3 = '0;
  logic [31:0]      req_addr = '0, req_wdata = '0;
  logic             req_ready, resp_valid, resp_err, mem_wr_en;
  logic             resp_ready = 1'b1;
  logic [31:0]      resp_rdata, mem_wdata, mem_rdata;
  logic [IDX_W-1:0] mem_addr;

  logic [31:0] dmem    [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  int          n_chk = 0, n_pass = 0;

  load_store_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < DEPTH) ? dmem[mem_addr[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_wr_en) begin
      wr_cnt = wr_cnt + 1;
      last_wr_addr = mem_addr;
      if (mem_addr < DEPTH) dmem[mem_addr[4:0]] = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit ref_illegal(input bit we, input int f3, input logic [31:0] addr);
    if (addr / 4 >= DEPTH) return 1;
    case (f3)
      0:       return 0;
      1:       return (addr % 2) != 0;
      2:       return (addr % 4) != 0;
      4:       return we;
      5:       return we || (addr % 2) != 0;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input logic [31:0] addr);
    logic [31:0] w, v;
    int sh;
    w  = ref_mem[addr / 4];
    sh = int'(addr % 4) * 8;
    case (f3)
      0: begin v = (w >> sh) % 256;   if (v > 127)   v = v - 256;   end
      4:       v = (w >> sh) % 256;
      1: begin v = (w >> sh) % 65536; if (v > 32767) v = v - 65536; end
      5:       v = (w >> sh) % 65536;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic ref_store(input int f3, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] mask, w;
    int sh;
    sh   = int'(addr % 4) * 8;
    mask = (f3 == 0) ? 32'hFF : (f3 == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    w    = ref_mem[addr / 4];
    ref_mem[addr / 4] = (w & ~(mask << sh)) | ((wd & mask) << sh);
  endtask

  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold, input string tag);
    bit ill;
    int exp_lat, exp_wr, lat, w0;
    logic [31:0] exp_rd;
    ill     = ref_illegal(we, int'(f3), addr);
    exp_lat = ill ? 1 : (we && f3 != 3'b010) ? 3 : 2;
    exp_wr  = (!ill && we) ? 1 : 0;
    exp_rd  = (ill || we) ? 32'h0 : ref_load(int'(f3), addr);
    if (!ill && we) ref_store(int'(f3), addr, wd);

    @(negedge clk);
    chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    resp_ready = (hold == 0);
    w0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, resp_rdata, exp_rd);
    chk({tag, " err"}, 32'(resp_err), 32'(ill));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " hold rdata"}, resp_rdata, exp_rd);
      chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " resp_valid cleared"}, 32'(resp_valid), 32'd0);
    chk({tag, " back to idle"}, 32'(req_ready), 32'd1);
    chk({tag, " write pulses"}, 32'(wr_cnt - w0), 32'(exp_wr));
    if (exp_wr == 1) begin
      chk({tag, " write index"}, last_wr_addr, addr / 4);
      chk({tag, " mem word"}, dmem[addr / 4], ref_mem[addr / 4]);
    end
  endtask

  initial begin
    logic [31:0] v, a;
    logic [2:0]  f3s [7];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      dmem[i] = v;
      ref_mem[i] = v;
    end

    #1;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    txn(1, 3'b010, 32'h8, 32'hDEADBEEF, 0, "SW 8");
    txn(0, 3'b010, 32'h8, 32'h0, 0, "LW 8");
    txn(0, 3'b000, 32'hB, 32'h0, 0, "LB B");
    txn(0, 3'b100, 32'hB, 32'h0, 0, "LBU B");
    txn(0, 3'b001, 32'h8, 32'h0, 0, "LH 8");
    txn(0, 3'b101, 32'hA, 32'h0, 0, "LHU A");
    txn(1, 3'b000, 32'h9, 32'h12, 0, "SB 9");
    txn(0, 3'b010, 32'h8, 32'h0, 0, "LW 8 merged");
    chk("SB merged word", ref_mem[2], 32'hDEAD12EF);
    txn(0, 3'b010, 32'h6, 32'h0, 0, "LW 6 misaligned");
    txn(1, 3'b001, 32'h3, 32'h1234, 0, "SH 3 misaligned");
    txn(0, 3'b010, 32'h80, 32'h0, 0, "LW 80 range");
    txn(1, 3'b100, 32'h4, 32'h1, 0, "SBU illegal");
    txn(0, 3'b010, 32'h8, 32'h0, 4, "LW held");

    // Reset in MERGE of an SH must abort the write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'hA; req_wdata = 32'h5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("merge wr_en high", 32'(mem_wr_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort wr_en low", 32'(mem_wr_en), 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort resp_valid", 32'(resp_valid), 32'd0);
    chk("abort mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort word unchanged", dmem[2], ref_mem[2]);

    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 4 * DEPTH + 31));
      txn(1'($urandom_range(0, 1)), f3s[$urandom_range(0, 6)], a, $urandom,
          int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
    end

    for (int i = 0; i < DEPTH; i++) chk($sformatf("final word %0d", i), dmem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
